// File: rtl/dram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dram_arb_pkg
// Purpose  : Shared FSM encodings and id-width helper for the DRAM arbiter
//            and its round-robin picker.
// Revision : 1.0 - initial release
// ============================================================================
package dram_arb_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_LOCKED = 2'd3
    } arb_state_t;

    // Largest supported hart count and its id width
    localparam int MAX_NHART = 8;
    localparam int MAX_ID_W  = $clog2(MAX_NHART);

    // Id width for n requesters; a single requester still needs one bit
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/m_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : m_rr_pick
// Purpose  : Combinational round-robin picker. Returns the first requester
//            strictly after i_last, wrapping N-1 -> 0.
// Revision : 1.0 - initial release
// ============================================================================
module m_rr_pick #(
    parameter int N    = 2,
    parameter int ID_W = 1
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_last,
    output logic            o_valid,
    output logic [ID_W-1:0] o_id
);

    int v_idx;

    // Scan from farthest to nearest so the nearest requester after i_last wins
    always_comb begin
        o_valid = 1'b0;
        o_id    = '0;
        v_idx   = 0;
        for (int k = N; k >= 1; k--) begin
            v_idx = int'(i_last) + k;
            if (v_idx >= N) begin
                v_idx = v_idx - N;
            end
            if (i_req[v_idx]) begin
                o_valid = 1'b1;
                o_id    = ID_W'(v_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/m_dram_arb.sv
`default_nettype none
// ============================================================================
// Module   : m_dram_arb
// Purpose  : N-hart DRAM arbiter. Latches pulse requests per hart, grants
//            round-robin, and supports a per-hart lock with idle timeout so
//            page walks / AMO sequences run back-to-back.
// Revision : 1.0 - initial release
// ============================================================================
module m_dram_arb
    import dram_arb_pkg::*;
#(
    parameter int NHART    = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int CTRL_W   = 3,
    parameter int LOCK_TMO = 16
) (
    input  logic                    CLK,
    input  logic                    RST_X,
    input  logic [NHART*ADDR_W-1:0] w_req_addr,
    input  logic [NHART*DATA_W-1:0] w_req_wdata,
    input  logic [NHART*CTRL_W-1:0] w_req_ctrl,
    input  logic [NHART-1:0]        w_req_we,
    input  logic [NHART-1:0]        w_req_le,
    input  logic [NHART-1:0]        w_req_lock,
    output logic [NHART-1:0]        w_req_busy,
    output logic [DATA_W-1:0]       w_req_odata,
    output logic [ADDR_W-1:0]       w_dram_addr,
    output logic [DATA_W-1:0]       w_dram_wdata,
    output logic [CTRL_W-1:0]       w_dram_ctrl,
    output logic                    w_dram_we_t,
    output logic                    w_dram_le,
    input  logic [DATA_W-1:0]       w_dram_odata,
    input  logic                    w_dram_busy,
    output logic [NHART-1:0]        w_grant
);

    localparam int ID_W  = id_w(NHART);
    localparam int TMO_W = $clog2(LOCK_TMO + 1);

    // Per-hart request slices
    logic [ADDR_W-1:0] w_in_addr  [NHART];
    logic [DATA_W-1:0] w_in_wdata [NHART];
    logic [CTRL_W-1:0] w_in_ctrl  [NHART];

    for (genvar gi = 0; gi < NHART; gi++) begin : g_unpack
        assign w_in_addr[gi]  = w_req_addr[gi*ADDR_W +: ADDR_W];
        assign w_in_wdata[gi] = w_req_wdata[gi*DATA_W +: DATA_W];
        assign w_in_ctrl[gi]  = w_req_ctrl[gi*CTRL_W +: CTRL_W];
    end

    // Latched request state
    logic [NHART-1:0]  r_pending;
    logic [NHART-1:0]  r_we;
    logic [ADDR_W-1:0] r_addr  [NHART];
    logic [DATA_W-1:0] r_wdata [NHART];
    logic [CTRL_W-1:0] r_ctrl  [NHART];

    // Arbiter state
    arb_state_t        r_state;
    logic [NHART-1:0]  r_grant;
    logic [ID_W-1:0]   r_gid;
    logic [ID_W-1:0]   r_last;
    logic [TMO_W-1:0]  r_tmo;
    logic [DATA_W-1:0] r_odata;

    logic [NHART-1:0]  w_strobe;
    logic [NHART-1:0]  w_accept;
    logic              w_done;
    logic              w_own_req;
    logic              w_active;
    logic              w_pick_vld;
    logic [ID_W-1:0]   w_pick_id;

    // A write strobe wins when both strobes arrive together
    assign w_strobe   = w_req_we | w_req_le;
    assign w_accept   = w_strobe & ~r_pending;
    assign w_req_busy = r_pending | w_strobe;
    assign w_done     = (r_state == ST_WAIT) && !w_dram_busy;
    assign w_own_req  = r_pending[r_gid] | w_accept[r_gid];

    m_rr_pick #(
        .N    (NHART),
        .ID_W (ID_W)
    ) u_pick (
        .i_req   (r_pending),
        .i_last  (r_last),
        .o_valid (w_pick_vld),
        .o_id    (w_pick_id)
    );

    // Capture new requests; retire the granted hart's request on completion
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_pending <= '0;
            r_we      <= '0;
            for (int i = 0; i < NHART; i++) begin
                r_addr[i]  <= '0;
                r_wdata[i] <= '0;
                r_ctrl[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NHART; i++) begin
                if (w_accept[i]) begin
                    r_pending[i] <= 1'b1;
                    r_we[i]      <= w_req_we[i];
                    r_addr[i]    <= w_in_addr[i];
                    r_wdata[i]   <= w_in_wdata[i];
                    r_ctrl[i]    <= w_in_ctrl[i];
                end else if (w_done && (r_gid == ID_W'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // Arbitration FSM: select, issue one strobe, wait, optionally hold lock
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_gid   <= '0;
            r_last  <= ID_W'(NHART - 1);
            r_tmo   <= '0;
            r_odata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_gid              <= w_pick_id;
                        r_grant            <= '0;
                        r_grant[w_pick_id] <= 1'b1;
                        r_state            <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!w_dram_busy) begin
                        if (!r_we[r_gid]) begin
                            r_odata <= w_dram_odata;
                        end
                        r_last <= r_gid;
                        if (w_req_lock[r_gid]) begin
                            r_tmo   <= TMO_W'(LOCK_TMO);
                            r_state <= ST_LOCKED;
                        end else begin
                            r_grant <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Owner's follow-on request skips the IDLE selection cycle
                    if (w_own_req) begin
                        r_state <= ST_ISSUE;
                    end else if (!w_req_lock[r_gid] || (r_tmo <= TMO_W'(1))) begin
                        r_grant <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Downstream port follows the granted hart's latched request
    assign w_active     = |r_grant;
    assign w_dram_addr  = w_active ? r_addr[r_gid]  : '0;
    assign w_dram_wdata = w_active ? r_wdata[r_gid] : '0;
    assign w_dram_ctrl  = w_active ? r_ctrl[r_gid]  : '0;
    assign w_dram_we_t  = (r_state == ST_ISSUE) &&  r_we[r_gid];
    assign w_dram_le    = (r_state == ST_ISSUE) && !r_we[r_gid];
    assign w_req_odata  = r_odata;
    assign w_grant      = r_grant;

`ifdef SIM_MODE
    // Report strobes that arrive while the hart is still busy
    always @(posedge CLK) begin
        for (int i = 0; i < NHART; i++) begin
            if (RST_X && w_strobe[i] && r_pending[i]) begin
                $display("m_dram_arb: protocol error, hart %0d strobed while busy; request ignored", i);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_m_dram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_dram_arb
// Purpose  : Self-checking bench for m_dram_arb (4 harts, lock timeout 4).
//            Expected downstream accesses go into a queue; a monitor pops
//            and compares on every downstream strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_dram_arb;

    localparam int NH = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 3;

    logic             CLK;
    logic             RST_X;
    logic [NH*AW-1:0] req_addr;
    logic [NH*DW-1:0] req_wdata;
    logic [NH*CW-1:0] req_ctrl;
    logic [NH-1:0]    req_we;
    logic [NH-1:0]    req_le;
    logic [NH-1:0]    req_lock;
    logic [NH-1:0]    req_busy;
    logic [DW-1:0]    req_odata;
    logic [AW-1:0]    dram_addr;
    logic [DW-1:0]    dram_wdata;
    logic [CW-1:0]    dram_ctrl;
    logic             dram_we_t;
    logic             dram_le;
    logic [DW-1:0]    dram_odata;
    logic             dram_busy;
    logic [NH-1:0]    grant;

    typedef struct {
        int          hart;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctrl;
    } exp_t;

    exp_t sbq[$];
    int   checks    = 0;
    int   failures  = 0;
    int   n_strobes = 0;
    int   ctl_lat   = 2;
    int   ctl_cnt;

    m_dram_arb #(
        .NHART    (NH),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .CTRL_W   (CW),
        .LOCK_TMO (4)
    ) dut (
        .CLK          (CLK),
        .RST_X        (RST_X),
        .w_req_addr   (req_addr),
        .w_req_wdata  (req_wdata),
        .w_req_ctrl   (req_ctrl),
        .w_req_we     (req_we),
        .w_req_le     (req_le),
        .w_req_lock   (req_lock),
        .w_req_busy   (req_busy),
        .w_req_odata  (req_odata),
        .w_dram_addr  (dram_addr),
        .w_dram_wdata (dram_wdata),
        .w_dram_ctrl  (dram_ctrl),
        .w_dram_we_t  (dram_we_t),
        .w_dram_le    (dram_le),
        .w_dram_odata (dram_odata),
        .w_dram_busy  (dram_busy),
        .w_grant      (grant)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Controller model: busy for ctl_lat cycles after a strobe, read data = addr ^ 0x5EADBEEF
    always @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            dram_busy  <= 1'b0;
            ctl_cnt    <= 0;
            dram_odata <= '0;
        end else if (dram_we_t || dram_le) begin
            dram_busy  <= 1'b1;
            ctl_cnt    <= ctl_lat;
            dram_odata <= dram_addr ^ 32'h5EAD_BEEF;
        end else if (dram_busy) begin
            if (ctl_cnt <= 1) dram_busy <= 1'b0;
            ctl_cnt <= ctl_cnt - 1;
        end
    end

    // Monitor: every downstream strobe must match the head of the queue
    always @(negedge CLK) begin
        exp_t       e;
        logic [3:0] eg;
        #2;
        if (RST_X === 1'b1 && (dram_we_t === 1'b1 || dram_le === 1'b1)) begin
            n_strobes++;
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: strobe we=%b addr=%h with nothing expected", dram_we_t, dram_addr);
            end else begin
                e  = sbq.pop_front();
                eg = 4'b0001 << e.hart;
                if ({grant, dram_we_t, dram_le, dram_addr, dram_wdata, dram_ctrl} !==
                    {eg, e.we, ~e.we, e.addr, e.wdata, e.ctrl}) begin
                    failures++;
                    $display("FAIL sb_access: got grant=%b we=%b le=%b addr=%h wdata=%h ctrl=%0d required grant=%b we=%b addr=%h wdata=%h ctrl=%0d",
                             grant, dram_we_t, dram_le, dram_addr, dram_wdata, dram_ctrl,
                             eg, e.we, e.addr, e.wdata, e.ctrl);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic drive_req(input int h, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [2:0] c);
        req_addr[h*AW +: AW]  = a;
        req_wdata[h*DW +: DW] = d;
        req_ctrl[h*CW +: CW]  = c;
        req_we[h]             = w;
        req_le[h]             = ~w;
    endtask

    task automatic expect_acc(input int h, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [2:0] c);
        exp_t e;
        e.hart  = h;
        e.we    = w;
        e.addr  = a;
        e.wdata = d;
        e.ctrl  = c;
        sbq.push_back(e);
    endtask

    task automatic clr();
        req_we = '0;
        req_le = '0;
    endtask

    task automatic wait_clear(input int h, input string nm);
        int n;
        n = 0;
        tick();
        while (req_busy[h] === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk(nm, req_busy[h], 1'b0);
    endtask

    task automatic do_reset();
        RST_X    = 1'b0;
        req_lock = '0;
        clr();
        tick();
        tick();
        RST_X = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        int s0;
        RST_X     = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_ctrl  = '0;
        req_we    = '0;
        req_le    = '0;
        req_lock  = '0;
        tick();
        tick();

        // Reset state
        chk("rst_grant", grant, 0);
        chk("rst_busy", req_busy, 0);
        chk("rst_odata", req_odata, 0);
        chk("rst_le", dram_le, 0);
        chk("rst_we", dram_we_t, 0);
        chk("rst_addr", dram_addr, 0);
        RST_X = 1'b1;
        tick();

        // Single read, idle arbiter, controller busy 3 cycles
        ctl_lat = 3;
        drive_req(0, 1'b0, 32'h8000_0000, 32'h0, 3'd2);
        expect_acc(0, 1'b0, 32'h8000_0000, 32'h0, 3'd2);
        #1;
        chk("t1_busy_in_strobe_cycle", req_busy, 4'b0001);
        tick();
        clr();
        chk("t1_no_strobe_T1", dram_le, 0);
        tick();
        chk("t1_le_at_T2", dram_le, 1);
        n = 0;
        tick();
        while (dram_busy === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        chk("t1_ctl_busy_cycles", n, 3);
        chk("t1_busy_at_C", req_busy[0], 1);
        chk("t1_odata_at_C", req_odata, 0);
        tick();
        chk("t1_odata_C1", req_odata, 32'hDEAD_BEEF);
        chk("t1_busy_C1", req_busy, 0);
        chk("t1_grant_C1", grant, 0);

        // All four harts strobe together after reset: order 0,1,2,3
        do_reset();
        ctl_lat = 2;
        s0 = n_strobes;
        for (int h = 0; h < NH; h++) begin
            drive_req(h, (h % 2) == 0, 32'h1000_0000 + h * 32'h100, 32'hA0A0_0000 | h, 3'(h));
            expect_acc(h, (h % 2) == 0, 32'h1000_0000 + h * 32'h100, 32'hA0A0_0000 | h, 3'(h));
        end
        tick();
        clr();
        wait_clear(3, "t2_h3_done");
        chk("t2_strobe_count", n_strobes - s0, 4);
        chk("t2_odata_h3", req_odata, 32'h4EAD_BDEF);
        chk("t2_grant_idle", grant, 0);

        // Hart 1 locked burst of three reads while hart 0 waits
        ctl_lat  = 2;
        req_lock = 4'b0010;
        drive_req(1, 1'b0, 32'h2000_0010, 32'h11, 3'd2);
        expect_acc(1, 1'b0, 32'h2000_0010, 32'h11, 3'd2);
        expect_acc(1, 1'b0, 32'h2000_0020, 32'h12, 3'd2);
        expect_acc(1, 1'b0, 32'h2000_0030, 32'h13, 3'd2);
        expect_acc(0, 1'b0, 32'h3000_0000, 32'h10, 3'd2);
        tick();
        clr();
        drive_req(0, 1'b0, 32'h3000_0000, 32'h10, 3'd2);
        tick();
        clr();
        wait_clear(1, "t3_r1_done");
        chk("t3_lock_grant", grant, 4'b0010);
        drive_req(1, 1'b0, 32'h2000_0020, 32'h12, 3'd2);
        tick();
        clr();
        chk("t3_follow2_le_T1", dram_le, 1);
        chk("t3_follow2_addr", dram_addr, 32'h2000_0020);
        wait_clear(1, "t3_r2_done");
        drive_req(1, 1'b0, 32'h2000_0030, 32'h13, 3'd2);
        tick();
        clr();
        chk("t3_follow3_le_T1", dram_le, 1);
        chk("t3_follow3_addr", dram_addr, 32'h2000_0030);
        wait_clear(1, "t3_r3_done");
        req_lock = '0;
        wait_clear(0, "t3_h0_done");
        chk("t3_odata_h0", req_odata, 32'h6EAD_BEEF);

        // Lock held by idle hart 2 times out after 4 cycles; hart 3 next
        req_lock = 4'b0100;
        drive_req(2, 1'b0, 32'h7000_0000, 32'h22, 3'd4);
        expect_acc(2, 1'b0, 32'h7000_0000, 32'h22, 3'd4);
        expect_acc(3, 1'b1, 32'h7100_0000, 32'hCAFE_0003, 3'd5);
        tick();
        clr();
        drive_req(3, 1'b1, 32'h7100_0000, 32'hCAFE_0003, 3'd5);
        tick();
        clr();
        wait_clear(2, "t4_h2_done");
        n = 0;
        while (grant === 4'b0100 && n < 20) begin
            n++;
            tick();
        end
        chk("t4_lock_hold_cycles", n, 4);
        chk("t4_grant_released", grant, 0);
        req_lock = '0;
        tick();
        chk("t4_next_grant", grant, 4'b1000);
        chk("t4_next_we", dram_we_t, 1);
        wait_clear(3, "t4_h3_done");

        // Duplicate strobe while busy is ignored
        ctl_lat = 4;
        drive_req(0, 1'b0, 32'h4000_0000, 32'h33, 3'd1);
        expect_acc(0, 1'b0, 32'h4000_0000, 32'h33, 3'd1);
        tick();
        clr();
        tick();
        tick();
        drive_req(0, 1'b0, 32'h4444_4444, 32'h44, 3'd7);
        #1;
        chk("t5_busy_during_dup", req_busy[0], 1);
        tick();
        clr();
        wait_clear(0, "t5_done");
        chk("t5_odata", req_odata, 32'h1EAD_BEEF);
        repeat (4) tick();
        chk("t5_no_replay_busy", req_busy, 0);
        chk("t5_no_replay_grant", grant, 0);

        // Reset during WAIT, then a fresh access
        ctl_lat = 5;
        drive_req(0, 1'b0, 32'h5000_0000, 32'h55, 3'd2);
        expect_acc(0, 1'b0, 32'h5000_0000, 32'h55, 3'd2);
        tick();
        clr();
        tick();
        tick();
        chk("t6_in_wait", dram_busy, 1);
        RST_X = 1'b0;
        #1;
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_busy", req_busy, 0);
        chk("t6_rst_strobes", {dram_we_t, dram_le}, 0);
        chk("t6_rst_addr", dram_addr, 0);
        chk("t6_rst_wdata_ctrl", {dram_wdata, dram_ctrl}, 0);
        chk("t6_rst_odata", req_odata, 0);
        tick();
        RST_X = 1'b1;
        tick();
        drive_req(0, 1'b0, 32'h6000_0000, 32'h66, 3'd2);
        expect_acc(0, 1'b0, 32'h6000_0000, 32'h66, 3'd2);
        tick();
        clr();
        wait_clear(0, "t6_fresh_done");
        chk("t6_fresh_odata", req_odata, 32'h3EAD_BEEF);
        chk("t6_fresh_grant", grant, 0);

        repeat (3) tick();
        chk("sb_drain", sbq.size(), 0);
        chk("total_strobes", n_strobes, 14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
